// File: rtl/carus_exec_timer_pkg.sv
// -----------------------------------------------------------------------------
// carus_exec_timer_pkg
// Shared types and constants for the NM-Carus execution timer.
//   state_e                  : FSM state encoding (2 bits)
//   POST_TRIG_CYCLES_DEFAULT : default length of the post-run trigger window
//   RUN_CNT_WIDTH            : width of the saturating completed-run counter
// -----------------------------------------------------------------------------
package carus_exec_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int unsigned POST_TRIG_CYCLES_DEFAULT = 16;
  localparam int unsigned RUN_CNT_WIDTH            = 16;

endpackage

// File: rtl/carus_exec_timer_rise_edge_det.sv
// -----------------------------------------------------------------------------
// rise_edge_det
// Registers a level input and flags the cycle in which it is high while its
// registered copy is still low.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (register clears to 0)
//   d_i    : level input
//   rise_o : high for the cycle in which d_i rose
// -----------------------------------------------------------------------------
module rise_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  // A level already high when reset releases counts as a rise, since d_q
  // comes out of reset at 0.
  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/carus_exec_timer.sv
// -----------------------------------------------------------------------------
// carus_exec_timer
// Measures NM-Carus execution time in clock cycles between a start rising edge
// and a done rising edge, keeps last/max/count statistics, drives a trigger
// window for a data dump and guards each run with an optional watchdog.
//   clk_i            : clock, rising edge
//   rst_ni           : asynchronous active-low reset
//   clear_i          : synchronous clear of FSM and statistics
//   start_i, done_i  : NM-Carus start / done levels
//   timeout_cycles_i : watchdog limit in cycles, 0 disables it
//   busy_o           : a run is in progress
//   trig_o           : dump window (run plus post-run hold)
//   valid_o          : one-cycle pulse when last_cycles_o is updated
//   last_cycles_o    : duration of the most recent completed run
//   max_cycles_o     : longest completed run since reset/clear
//   run_cnt_o        : completed runs, saturating
//   timeout_o        : sticky watchdog expiry
// -----------------------------------------------------------------------------
module carus_exec_timer
  import carus_exec_timer_pkg::*;
#(
  parameter int unsigned CntWidth       = 32,
  parameter int unsigned PostTrigCycles = POST_TRIG_CYCLES_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     start_i,
  input  logic                     done_i,
  input  logic [CntWidth-1:0]      timeout_cycles_i,
  output logic                     busy_o,
  output logic                     trig_o,
  output logic                     valid_o,
  output logic [CntWidth-1:0]      last_cycles_o,
  output logic [CntWidth-1:0]      max_cycles_o,
  output logic [RUN_CNT_WIDTH-1:0] run_cnt_o,
  output logic                     timeout_o
);

  // The hold counter runs 0 .. PostTrigCycles-1; keep it at least one bit wide
  // so the design still elaborates when the hold window is disabled.
  localparam int unsigned HoldWidth = (PostTrigCycles > 2) ? $clog2(PostTrigCycles) : 1;
  localparam logic [HoldWidth-1:0] HoldLast =
    HoldWidth'((PostTrigCycles > 0) ? (PostTrigCycles - 1) : 0);
  localparam bit HoldEnabled = (PostTrigCycles != 0);

  state_e                   state_q, state_d;
  logic                     start_rise, done_rise;
  logic [CntWidth-1:0]      cnt_q, cnt_inc;
  logic [HoldWidth-1:0]     hold_q;
  logic [RUN_CNT_WIDTH-1:0] run_cnt_inc;
  logic                     wd_hit;

  // FSM side effects requested by the next-state logic
  logic cnt_clr;
  logic run_done;
  logic hold_clr;
  logic hold_inc;
  logic to_set;

  rise_edge_det u_start_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (start_i),
    .rise_o (start_rise)
  );

  rise_edge_det u_done_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (done_i),
    .rise_o (done_rise)
  );

  // cnt holds (cycles in RUN - 1); cnt+1 is the run length if done rises now.
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CntWidth'(1);
  assign run_cnt_inc = (&run_cnt_o) ? run_cnt_o : run_cnt_o + RUN_CNT_WIDTH'(1);
  assign wd_hit      = (timeout_cycles_i != '0) && (cnt_inc >= timeout_cycles_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    run_done = 1'b0;
    hold_clr = 1'b0;
    hold_inc = 1'b0;
    to_set   = 1'b0;

    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            state_d = ST_RUN;
            cnt_clr = 1'b1;
          end
        end
        ST_RUN: begin
          // A done edge wins over a watchdog hit in the same cycle.
          if (done_rise) begin
            run_done = 1'b1;
            hold_clr = 1'b1;
            state_d  = HoldEnabled ? ST_HOLD : ST_IDLE;
          end else if (wd_hit) begin
            to_set  = 1'b1;
            state_d = ST_TIMEOUT;
          end
        end
        ST_HOLD: begin
          if (hold_q == HoldLast) begin
            state_d = ST_IDLE;
          end else begin
            hold_inc = 1'b1;
          end
        end
        ST_TIMEOUT: begin
          state_d = ST_TIMEOUT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Decoded from the registered state only: no input reaches these outputs.
  always_comb begin
    busy_o = (state_q == ST_RUN);
    trig_o = (state_q == ST_RUN) || (state_q == ST_HOLD);
  end

  // Counters and statistics. Clear leaves the edge-detect registers alone so a
  // level that is already high is not re-interpreted as a new edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q         <= '0;
      hold_q        <= '0;
      valid_o       <= 1'b0;
      last_cycles_o <= '0;
      max_cycles_o  <= '0;
      run_cnt_o     <= '0;
      timeout_o     <= 1'b0;
    end else if (clear_i) begin
      cnt_q         <= '0;
      hold_q        <= '0;
      valid_o       <= 1'b0;
      last_cycles_o <= '0;
      max_cycles_o  <= '0;
      run_cnt_o     <= '0;
      timeout_o     <= 1'b0;
    end else begin
      valid_o <= run_done;

      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
        cnt_q <= cnt_inc;
      end

      if (hold_clr) begin
        hold_q <= '0;
      end else if (hold_inc) begin
        hold_q <= hold_q + HoldWidth'(1);
      end

      if (run_done) begin
        last_cycles_o <= cnt_inc;
        run_cnt_o     <= run_cnt_inc;
        if (cnt_inc > max_cycles_o) begin
          max_cycles_o <= cnt_inc;
        end
      end

      if (to_set) begin
        timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_carus_exec_timer.sv
// -----------------------------------------------------------------------------
// tb_carus_exec_timer
// Self-checking bench for carus_exec_timer. Completed runs push their expected
// statistics onto a scoreboard; a monitor pops one entry per valid_o pulse.
// -----------------------------------------------------------------------------
module tb_carus_exec_timer;

  localparam int CW = 32;
  localparam int P  = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          done  = 1'b0;
  logic [CW-1:0] tmo   = '0;

  logic          busy, trig, valid, timeout;
  logic [CW-1:0] last_cycles, max_cycles;
  logic [15:0]   run_cnt;

  carus_exec_timer #(
    .CntWidth       (CW),
    .PostTrigCycles (P)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .clear_i          (clear),
    .start_i          (start),
    .done_i           (done),
    .timeout_cycles_i (tmo),
    .busy_o           (busy),
    .trig_o           (trig),
    .valid_o          (valid),
    .last_cycles_o    (last_cycles),
    .max_cycles_o     (max_cycles),
    .run_cnt_o        (run_cnt),
    .timeout_o        (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int            exp_cyc;
    logic [CW-1:0] last;
    logic [CW-1:0] max;
    logic [15:0]   rc;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_e;

  always @(negedge clk) begin
    if (rst_n && valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("valid_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("valid_cycle", cyc, mon_e.exp_cyc);
        check("last_cycles", last_cycles, mon_e.last);
        check("max_cycles", max_cycles, mon_e.max);
        check("run_cnt", run_cnt, mon_e.rc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Called just after a rising edge; the start edge falls in the current cycle
  // Ts and done rises at Ts+len. Checks busy/trig every cycle up to the first
  // IDLE cycle after the hold window.
  task automatic do_run(input int len, input logic [CW-1:0] exp_last,
                        input logic [CW-1:0] exp_max, input logic [15:0] exp_rc);
    int ts;
    ts = cyc;
    start = 1'b1;
    sb_q.push_back('{ts + len + 1, exp_last, exp_max, exp_rc});
    for (int k = 0; k <= len + P + 1; k++) begin
      if (k == len) done = 1'b1;
      @(negedge clk);
      check("busy_run", busy, (k >= 1 && k <= len));
      check("trig_run", trig, (k >= 1 && k <= len + P));
      tick();
      if (k == 0) start = 1'b0;
      if (k == len) done = 1'b0;
    end
    check("sb_empty_after_run", sb_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            clr;
    int            len;
    logic [CW-1:0] tmo;
    logic [CW-1:0] exp_last;
    logic [CW-1:0] exp_max;
    logic [15:0]   exp_rc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #300000;
    $display("FAIL global_time_limit: got running, expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int ts;

    vecs[0] = '{1'b0, 100, 32'd0,  32'd100, 32'd100, 16'd1};
    vecs[1] = '{1'b1,  50, 32'd0,  32'd50,  32'd50,  16'd1};
    vecs[2] = '{1'b0,  30, 32'd30, 32'd30,  32'd50,  16'd2}; // done and watchdog coincide
    vecs[3] = '{1'b0,   1, 32'd0,  32'd1,   32'd50,  16'd3};
    vecs[4] = '{1'b0,  64, 32'd0,  32'd64,  32'd64,  16'd4};
    vecs[5] = '{1'b0,   2, 32'd3,  32'd2,   32'd64,  16'd5};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_trig", trig, 0);
    check("rst_valid", valid, 0);
    check("rst_last", last_cycles, 0);
    check("rst_max", max_cycles, 0);
    check("rst_run_cnt", run_cnt, 0);
    check("rst_timeout", timeout, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- table-driven runs ----
    for (int i = 0; i < 6; i++) begin
      tmo = vecs[i].tmo;
      if (vecs[i].clr) begin
        do_clear();
        @(negedge clk);
        check("clr_last", last_cycles, 0);
        check("clr_max", max_cycles, 0);
        check("clr_run_cnt", run_cnt, 0);
        tick();
      end
      do_run(vecs[i].len, vecs[i].exp_last, vecs[i].exp_max, vecs[i].exp_rc);
    end
    tmo = '0;

    // ---- watchdog: 20 cycles in RUN, then TIMEOUT ----
    do_clear();
    tmo = 32'd20;
    start = 1'b1;
    for (int k = 0; k <= 23; k++) begin
      @(negedge clk);
      check("wd_busy", busy, (k >= 1 && k <= 20));
      check("wd_trig", trig, (k >= 1 && k <= 20));
      check("wd_timeout", timeout, (k >= 21));
      tick();
      if (k == 0) start = 1'b0;
    end
    check("wd_run_cnt", run_cnt, 0);
    check("wd_last", last_cycles, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("wd_restart_busy", busy, 0);
    check("wd_restart_timeout", timeout, 1);
    check("wd_restart_trig", trig, 0);
    tick();
    do_clear();
    @(negedge clk);
    check("wd_clear_timeout", timeout, 0);
    check("wd_clear_busy", busy, 0);
    tick();
    tmo = '0;

    // ---- start+done together in IDLE, second start in RUN and HOLD ----
    do_clear();
    ts = cyc;
    start = 1'b1;
    done  = 1'b1;
    tick();
    start = 1'b0;
    done  = 1'b0;
    @(negedge clk);
    check("same_edge_busy", busy, 1);
    while (cyc < ts + 20) begin
      start = (cyc == ts + 5);
      tick();
    end
    start = 1'b0;
    sb_q.push_back('{ts + 21, 32'd20, 32'd20, 16'd1});
    done = 1'b1;
    tick();
    done = 1'b0;
    while (cyc < ts + 20 + P + 2) begin
      start = (cyc == ts + 23);
      done  = (cyc == ts + 23);
      @(negedge clk);
      check("hold_busy", busy, 0);
      check("hold_trig", trig, (cyc <= ts + 20 + P));
      tick();
    end
    start = 1'b0;
    done  = 1'b0;
    check("hold_run_cnt", run_cnt, 1);
    check("hold_sb_empty", sb_q.size(), 0);

    // ---- reset mid-run at cnt=40, start still high at release ----
    ts = cyc;
    start = 1'b1;
    while (cyc < ts + 41) tick();
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_trig", trig, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_last", last_cycles, 0);
    check("mid_rst_max", max_cycles, 0);
    check("mid_rst_run_cnt", run_cnt, 0);
    check("mid_rst_timeout", timeout, 0);
    tick();
    rst_n = 1'b1;
    do_run(10, 32'd10, 32'd10, 16'd1);

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
